// File: rtl/serial_byte_tx.sv
// Framed parallel-to-serial transmitter: START, WIDTH data bits MSB first, STOP.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and STOP.
module serial_byte_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    // Parity is taken from the word at capture time; the shift register is destroyed as it sends.
    logic             par_q, par_d;
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = S_START;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            S_START: state_d = S_DATA;
            S_DATA: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: state_d = S_STOP;
`endif
            S_STOP: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs decode registered state only; din and load never reach sout combinationally.
    always_comb begin
        sout = 1'b1;
        case (state_q)
            S_START:  sout = 1'b0;
            S_DATA:   sout = shreg_q[WIDTH-1];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: sout = par_q;
`endif
            default:  sout = 1'b1;
        endcase
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Scoreboard bench for serial_byte_tx: stimulus queues expected line bits, a negedge monitor checks them.
// Build with SERIAL_TX_PARITY_EN defined to check the parity variant.
module tb_serial_byte_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       load;
    logic       ready, sout, busy, done;

    serial_byte_tx #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .load (load),
        .ready(ready),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } item_t;

    item_t      exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic       mon_en   = 1'b0;
    logic       done_pending = 1'b0;
    logic [7:0] rx_q = 8'h00;

    // Receiver-side shift register fed from the serial line.
    always @(posedge clk) rx_q <= {rx_q[6:0], sout};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back('{b: 1'b0, last: 1'b0});
        for (int i = 7; i >= 0; i--) exp_q.push_back('{b: d[i], last: 1'b0});
`ifdef SERIAL_TX_PARITY_EN
        exp_q.push_back('{b: ^d, last: 1'b0});
`endif
        exp_q.push_back('{b: 1'b1, last: 1'b1});
    endtask

    // Returns one time unit after the accepting edge, i.e. inside the START cycle.
    task automatic send(input logic [7:0] d, input logic hold);
        int n = 0;
        din  = d;
        load = 1'b1;
        while (!ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            n_checks++;
            $display("FAIL send_timeout: ready never rose for din=%0h", d);
        end else begin
            @(posedge clk); #1;
            push_frame(d);
        end
        load = hold;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d expected bits left", exp_q.size());
            exp_q.delete();
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Monitor: every cycle the line state is compared to the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            logic  exp_busy;
            item_t it;
            exp_busy = (exp_q.size() != 0);
            check("busy",  {15'd0, busy},  {15'd0, exp_busy});
            check("ready", {15'd0, ready}, {15'd0, ~exp_busy});
            check("done",  {15'd0, done},  {15'd0, done_pending});
            if (exp_busy) begin
                it = exp_q.pop_front();
                check("sout_frame", {15'd0, sout}, {15'd0, it.b});
                done_pending = it.last;
            end else begin
                check("sout_idle", {15'd0, sout}, 16'd1);
                done_pending = 1'b0;
            end
        end
    end

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        din  = 8'h00;

        // Reset then idle
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end

        // Single frame: A5 -> 0,1,0,1,0,0,1,0,1,[0],1
        send(8'hA5, 1'b0);
        wait_idle();

        // Load during DATA bit 3 is ignored
        send(8'hFF, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        din  = 8'h00;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        wait_idle();

        // Back-to-back with load held high
        send(8'h81, 1'b1);
        send(8'h7E, 1'b0);
        wait_idle();

        // Reset during DATA bit 5 abandons the frame with no done pulse
        send(8'h3C, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        send(8'hC3, 1'b0);
        wait_idle();

        // Loopback: receiver holds the word after the eight data-bit edges, before STOP
        send(8'h5A, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        check("loopback_q", {8'd0, rx_q}, 16'h005A);
        wait_idle();

        repeat (3) begin @(posedge clk); #1; end
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
